// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
// Groups the ID/EX hazard inputs and the pipeline-control outputs of
// hazard_stall_ctrl into one bundle.
//   master : pipeline side; drives the hazard inputs and receives the controls
//   slave  : hazard_stall_ctrl; receives the hazard inputs and drives the controls
// Inputs : Rs1_i, Rs2_i, Rs1_used_i, Rs2_used_i, MemRead_EX_i, Rd_EX_i,
//          Mul_start_i, Branch_taken_i
// Outputs: PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Busy_o, Stall_cnt_o
interface hazard_stall_ctrl_if;
  logic [4:0]  Rs1_i;
  logic [4:0]  Rs2_i;
  logic        Rs1_used_i;
  logic        Rs2_used_i;
  logic        MemRead_EX_i;
  logic [4:0]  Rd_EX_i;
  logic        Mul_start_i;
  logic        Branch_taken_i;
  logic        PCWrite_o;
  logic        IF_ID_Write_o;
  logic        NoOp_o;
  logic        Flush_o;
  logic        Busy_o;
  logic [15:0] Stall_cnt_o;

  modport master (
    output Rs1_i, Rs2_i, Rs1_used_i, Rs2_used_i, MemRead_EX_i, Rd_EX_i,
           Mul_start_i, Branch_taken_i,
    input  PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Busy_o, Stall_cnt_o
  );

  modport slave (
    input  Rs1_i, Rs2_i, Rs1_used_i, Rs2_used_i, MemRead_EX_i, Rd_EX_i,
           Mul_start_i, Branch_taken_i,
    output PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Busy_o, Stall_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline hazard controller: detects load-use hazards between ID and EX,
// holds the front end while a multi-cycle multiply occupies EX, flushes
// IF/ID on a taken branch and keeps a saturating count of bubble cycles.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : hazard_stall_ctrl_if.slave (hazard inputs, pipeline controls)
// Parameter:
//   MUL_LATENCY : EX multiply latency in cycles, 1..15
// Build option:
//   MUL_STALL_EN : when defined, multiply stall sequencing is included;
//                  when undefined, Mul_start_i is ignored and Busy_o is 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; only load-use hazards stall
// MUL_BUSY | multiply occupying EX; front end held, bubbles inserted
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  hazard_stall_ctrl_if.slave bus
);

  logic        load_use;
  logic        mul_busy;
  logic        stall;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    load_use = bus.MemRead_EX_i && (bus.Rd_EX_i != 5'd0) &&
               ((bus.Rs1_used_i && (bus.Rs1_i == bus.Rd_EX_i)) ||
                (bus.Rs2_used_i && (bus.Rs2_i == bus.Rd_EX_i)));
  end

`ifdef MUL_STALL_EN
  typedef enum logic {RUN, MUL_BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      RUN: begin
        // A load-use bubble blocks issue; the multiply re-presents afterwards.
        if (bus.Mul_start_i && !load_use && (MUL_LATENCY > 1)) begin
          state_d   = MUL_BUSY;
          mul_cnt_d = 4'(MUL_LATENCY - 1);
        end
      end
      MUL_BUSY: begin
        mul_cnt_d = mul_cnt_q - 4'd1;
        if (mul_cnt_q == 4'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        mul_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign mul_busy = (state_q == MUL_BUSY);
`else
  // Multiply sequencing compiled out; these inputs are intentionally unused.
  logic unused_mul;
  assign unused_mul = bus.Mul_start_i ^ (MUL_LATENCY == 0);
  assign mul_busy   = 1'b0;
`endif

  assign stall = load_use || mul_busy;

  always_comb begin
    bus.PCWrite_o     = !stall;
    bus.IF_ID_Write_o = !stall;
    bus.NoOp_o        = stall;
    bus.Flush_o       = !stall && bus.Branch_taken_i;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Busy_o      = mul_busy;
  assign bus.Stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.MUL_LATENCY(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    bus.Rs1_i          = 5'd0;
    bus.Rs2_i          = 5'd0;
    bus.Rs1_used_i     = 1'b0;
    bus.Rs2_used_i     = 1'b0;
    bus.MemRead_EX_i   = 1'b0;
    bus.Rd_EX_i        = 5'd0;
    bus.Mul_start_i    = 1'b0;
    bus.Branch_taken_i = 1'b0;
  endtask

  task automatic load_use_rs1(input logic [4:0] r);
    bus.MemRead_EX_i = 1'b1;
    bus.Rd_EX_i      = r;
    bus.Rs1_i        = r;
    bus.Rs1_used_i   = 1'b1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    idle();
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_busy",    bus.Busy_o,        1'b0);
    chk("rst_cnt",     bus.Stall_cnt_o,   16'd0);
    chk("rst_pcwrite", bus.PCWrite_o,     1'b1);
    chk("rst_ifid",    bus.IF_ID_Write_o, 1'b1);
    chk("rst_noop",    bus.NoOp_o,        1'b0);
    chk("rst_flush",   bus.Flush_o,       1'b0);

    // load-use on Rs1
    load_use_rs1(5'd5);
    #1;
    chk("lu1_pcwrite", bus.PCWrite_o,     1'b0);
    chk("lu1_ifid",    bus.IF_ID_Write_o, 1'b0);
    chk("lu1_noop",    bus.NoOp_o,        1'b1);
    chk("lu1_flush",   bus.Flush_o,       1'b0);
    tick();
    idle();
    #1;
    chk("lu1_cnt", bus.Stall_cnt_o, 16'd1);

    // load-use on Rs2
    bus.MemRead_EX_i = 1'b1;
    bus.Rd_EX_i      = 5'd7;
    bus.Rs1_i        = 5'd3;
    bus.Rs1_used_i   = 1'b1;
    bus.Rs2_i        = 5'd7;
    bus.Rs2_used_i   = 1'b1;
    #1;
    chk("lu2_noop", bus.NoOp_o, 1'b1);
    bus.Rs2_used_i = 1'b0;
    #1;
    chk("lu2_unused_noop", bus.NoOp_o, 1'b0);
    bus.Rs2_used_i = 1'b1;
    tick();
    idle();
    #1;
    chk("lu2_cnt", bus.Stall_cnt_o, 16'd2);

    // no hazard: Rd=0, Rs1 not used, not a load
    bus.MemRead_EX_i = 1'b1;
    bus.Rd_EX_i      = 5'd0;
    bus.Rs1_i        = 5'd0;
    bus.Rs1_used_i   = 1'b1;
    #1;
    chk("rd0_pcwrite", bus.PCWrite_o, 1'b1);
    chk("rd0_noop",    bus.NoOp_o,    1'b0);
    bus.Rd_EX_i    = 5'd5;
    bus.Rs1_i      = 5'd5;
    bus.Rs1_used_i = 1'b0;
    #1;
    chk("unused_pcwrite", bus.PCWrite_o, 1'b1);
    bus.Rs1_used_i   = 1'b1;
    bus.MemRead_EX_i = 1'b0;
    #1;
    chk("noload_pcwrite", bus.PCWrite_o, 1'b1);
    tick();
    idle();
    #1;
    chk("nohaz_cnt", bus.Stall_cnt_o, 16'd2);

    // branch flush, suppressed under load-use
    bus.Branch_taken_i = 1'b1;
    #1;
    chk("br_flush",   bus.Flush_o,   1'b1);
    chk("br_pcwrite", bus.PCWrite_o, 1'b1);
    load_use_rs1(5'd9);
    #1;
    chk("br_lu_flush", bus.Flush_o, 1'b0);
    chk("br_lu_noop",  bus.NoOp_o,  1'b1);
    tick();
    idle();
    #1;
    chk("br_lu_cnt", bus.Stall_cnt_o, 16'd3);

`ifdef MUL_STALL_EN
    // multiply, latency 4 -> three busy cycles
    bus.Mul_start_i = 1'b1;
    #1;
    chk("mul_issue_noop",    bus.NoOp_o,    1'b0);
    chk("mul_issue_pcwrite", bus.PCWrite_o, 1'b1);
    tick();
    idle();
    #1;
    chk("mul_b1_busy",    bus.Busy_o,    1'b1);
    chk("mul_b1_noop",    bus.NoOp_o,    1'b1);
    chk("mul_b1_pcwrite", bus.PCWrite_o, 1'b0);
    tick();
    bus.Branch_taken_i = 1'b1;
    #1;
    chk("mul_b2_busy",  bus.Busy_o,  1'b1);
    chk("mul_b2_flush", bus.Flush_o, 1'b0);
    bus.Branch_taken_i = 1'b0;
    tick();
    chk("mul_b3_busy", bus.Busy_o, 1'b1);
    chk("mul_b3_noop", bus.NoOp_o, 1'b1);
    tick();
    chk("mul_done_busy",    bus.Busy_o,      1'b0);
    chk("mul_done_noop",    bus.NoOp_o,      1'b0);
    chk("mul_done_pcwrite", bus.PCWrite_o,   1'b1);
    chk("mul_done_cnt",     bus.Stall_cnt_o, 16'd6);

    // multiply blocked by load-use, then re-presented
    load_use_rs1(5'd4);
    bus.Mul_start_i = 1'b1;
    #1;
    chk("mul_lu_noop", bus.NoOp_o, 1'b1);
    tick();
    chk("mul_lu_busy", bus.Busy_o,      1'b0);
    chk("mul_lu_cnt",  bus.Stall_cnt_o, 16'd7);
    bus.MemRead_EX_i = 1'b0;
    #1;
    chk("mul_re_noop", bus.NoOp_o, 1'b0);
    tick();
    idle();
    #1;
    chk("mul_re_busy", bus.Busy_o, 1'b1);
    tick();
    tick();
    tick();
    chk("mul_re_done_busy", bus.Busy_o,      1'b0);
    chk("mul_re_done_cnt",  bus.Stall_cnt_o, 16'd10);

    // multiply with branch, then reset in second busy cycle
    bus.Mul_start_i    = 1'b1;
    bus.Branch_taken_i = 1'b1;
    #1;
    chk("mul_br_flush", bus.Flush_o, 1'b1);
    chk("mul_br_noop",  bus.NoOp_o,  1'b0);
    tick();
    idle();
    #1;
    chk("mul_br_busy", bus.Busy_o, 1'b1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("mul_rst_busy",    bus.Busy_o,      1'b0);
    chk("mul_rst_cnt",     bus.Stall_cnt_o, 16'd0);
    chk("mul_rst_pcwrite", bus.PCWrite_o,   1'b1);
    tick();
    chk("mul_rst_stay_busy", bus.Busy_o,      1'b0);
    chk("mul_rst_stay_cnt",  bus.Stall_cnt_o, 16'd0);
`else
    // multiply sequencing compiled out: Mul_start_i has no effect
    bus.Mul_start_i = 1'b1;
    #1;
    chk("nomul_noop",    bus.NoOp_o,    1'b0);
    chk("nomul_pcwrite", bus.PCWrite_o, 1'b1);
    tick();
    chk("nomul_busy", bus.Busy_o,      1'b0);
    chk("nomul_cnt",  bus.Stall_cnt_o, 16'd3);
    tick();
    chk("nomul_busy2", bus.Busy_o, 1'b0);
    chk("nomul_noop2", bus.NoOp_o, 1'b0);
    idle();
    load_use_rs1(5'd2);
    tick();
    chk("nomul_lu_cnt", bus.Stall_cnt_o, 16'd4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle();
    #1;
    chk("nomul_rst_cnt",     bus.Stall_cnt_o, 16'd0);
    chk("nomul_rst_pcwrite", bus.PCWrite_o,   1'b1);
`endif

    // saturation of the bubble counter
    do_reset();
    load_use_rs1(5'd1);
    repeat (65534) tick();
    chk("sat_fffe", bus.Stall_cnt_o, 16'hFFFE);
    tick();
    chk("sat_ffff", bus.Stall_cnt_o, 16'hFFFF);
    tick();
    chk("sat_hold", bus.Stall_cnt_o, 16'hFFFF);
    chk("sat_noop", bus.NoOp_o,      1'b1);
    tick();
    chk("sat_hold2", bus.Stall_cnt_o, 16'hFFFF);
    idle();
    tick();
    chk("sat_idle", bus.Stall_cnt_o, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
